// File: rtl/input_conditioner.sv
// Board input conditioning: two-flop synchronizers, per-button debounce FSMs with
// press pulses, and a stability filter for the slide-switch vector.
module input_conditioner #(
   parameter int NUM_BUTTONS     = 2,
   parameter int NUM_SWITCHES    = 10,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_BUTTONS-1:0]  buttons_raw,
   input  logic [NUM_SWITCHES-1:0] switches_raw,
   output logic [NUM_BUTTONS-1:0]  buttons,
   output logic [NUM_BUTTONS-1:0]  button_press,
   output logic [NUM_SWITCHES-1:0] switches,
   output logic                    switches_changed
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } btn_state_e;

   logic [NUM_BUTTONS-1:0]  btn_sync1, btn_sync2;
   logic [NUM_SWITCHES-1:0] sw_sync1, sw_sync2;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_sync1 <= '0;
         btn_sync2 <= '0;
         sw_sync1  <= '0;
         sw_sync2  <= '0;
      end else begin
         btn_sync1 <= buttons_raw;
         btn_sync2 <= btn_sync1;
         sw_sync1  <= switches_raw;
         sw_sync2  <= sw_sync1;
      end
   end

   btn_state_e             state_q [NUM_BUTTONS];
   btn_state_e             state_d [NUM_BUTTONS];
   logic [CNT_W-1:0]       cnt_q   [NUM_BUTTONS];
   logic [CNT_W-1:0]       cnt_d   [NUM_BUTTONS];
   logic [NUM_BUTTONS-1:0] press_d;
   logic [NUM_BUTTONS-1:0] level_d;

   // NOTE: every combinational output gets a default first, so no path through
   // the case statement can leave a value held and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = '0;
      level_d = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         unique case (state_q[i])
            LOW: begin
               if (btn_sync2[i]) begin
                  state_d[i] = RISE_CHK;
                  cnt_d[i]   = '0;
               end
            end
            RISE_CHK: begin
               if (!btn_sync2[i]) begin
                  state_d[i] = LOW;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = HIGH;
                  press_d[i] = 1'b1;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            HIGH: begin
               if (!btn_sync2[i]) begin
                  state_d[i] = FALL_CHK;
                  cnt_d[i]   = '0;
               end
            end
            FALL_CHK: begin
               if (btn_sync2[i]) begin
                  state_d[i] = HIGH;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = LOW;
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: state_d[i] = LOW;
         endcase
         level_d[i] = (state_d[i] == HIGH) || (state_d[i] == FALL_CHK);
      end
   end

   // Level and pulse are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_q[i] <= LOW;
            cnt_q[i]   <= '0;
         end
         buttons      <= '0;
         button_press <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         buttons      <= level_d;
         button_press <= press_d;
      end
   end

   logic [NUM_SWITCHES-1:0] sw_cand;
   logic [CNT_W-1:0]        sw_cnt;

   // The shared counter saturates at N-1; the load fires once per new stable value.
   always_ff @(posedge clk) begin
      if (rst) begin
         sw_cand          <= '0;
         sw_cnt           <= '0;
         switches         <= '0;
         switches_changed <= 1'b0;
      end else begin
         switches_changed <= 1'b0;
         if (sw_sync2 != sw_cand) begin
            sw_cand <= sw_sync2;
            sw_cnt  <= '0;
         end else if (sw_cnt != CNT_LAST) begin
            sw_cnt <= sw_cnt + CNT_W'(1);
         end else if (sw_cand != switches) begin
            switches         <= sw_cand;
            switches_changed <= 1'b1;
         end
      end
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NUM_BUTTONS, default 2, number of pushbutton inputs.
REQ-002 Parameter NUM_SWITCHES, default 10, number of slide-switch inputs.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, required consecutive stable synchronized cycles (N, legal range 1..65535).
REQ-004 Port clk  in  1  single clock for all logic.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Port buttons_raw  in  NUM_BUTTONS  asynchronous board pushbuttons.
REQ-007 Port switches_raw  in  NUM_SWITCHES  asynchronous board switches.
REQ-008 Port buttons  out  NUM_BUTTONS  debounced button levels, fed to the top_level buttons port.
REQ-009 Port button_press  out  NUM_BUTTONS  one-cycle pulse per debounced press.
REQ-010 Port switches  out  NUM_SWITCHES  filtered switch vector, fed to the top_level switches port.
REQ-011 Port switches_changed  out  1  one-cycle pulse when the switches output updates.

Function
REQ-012 Every raw bit SHALL pass through a two-flop synchronizer (sync1, sync2), both reset to 0; only sync2 feeds downstream logic.
REQ-013 Each button SHALL own an independent FSM with states LOW, RISE_CHK, HIGH, FALL_CHK and a counter of $clog2(N)+1 bits.
REQ-014 LOW: sync2=1 -> RISE_CHK with cnt=0; otherwise stay.
REQ-015 RISE_CHK: sync2=0 -> LOW (glitch rejected); sync2=1 and cnt==N-1 -> HIGH; sync2=1 otherwise -> cnt+1.
REQ-016 HIGH: sync2=0 -> FALL_CHK with cnt=0; otherwise stay.
REQ-017 FALL_CHK: sync2=1 -> HIGH; sync2=0 and cnt==N-1 -> LOW; sync2=0 otherwise -> cnt+1.
REQ-018 buttons[i] SHALL be registered, 1 in HIGH and FALL_CHK, 0 in LOW and RISE_CHK.
REQ-019 button_press[i] SHALL be 1 for exactly the first cycle buttons[i] reads 1 after a RISE_CHK->HIGH transition; no pulse on release or on FALL_CHK->HIGH.
REQ-020 Latency: raw sampled high at edge k and held -> buttons[i] and button_press[i] visible after edge k+N+2.
REQ-021 Any high pulse shorter than N+1 synchronized cycles SHALL produce no change on buttons or button_press.
REQ-022 Switch filter: a candidate register SHALL track sync2 vector; any bit change reloads candidate and clears a shared counter.
REQ-023 When the candidate has been unchanged for N consecutive cycles and differs from switches, switches SHALL load candidate and switches_changed SHALL pulse one cycle.
REQ-024 Counters SHALL saturate, never wrap; a held-stable input causes no further updates or pulses.
REQ-025 Buttons are independent; simultaneous presses on several buttons SHALL pulse in the same cycle when timing is identical.
REQ-026 N=1 SHALL be legal: RISE_CHK exits to HIGH on its first cycle with sync2=1.

Reset
REQ-027 rst=1 at a clock edge SHALL clear synchronizers, candidate, counters, buttons, button_press, switches, switches_changed to 0 and force all FSMs to LOW.
REQ-028 Reset asserted mid-count SHALL discard progress; an input held high across reset release SHALL be re-debounced and SHALL produce one button_press N+2 edges after first post-reset sampling.
REQ-029 No output SHALL change asynchronously to clk.

Verification
REQ-030 N=4, buttons_raw=01 held from edge k -> buttons=01 and button_press=01 after edge k+6; button_press=00 the following cycle.
REQ-031 N=4, buttons_raw[0] high for 3 cycles then low -> buttons and button_press remain 00 throughout.
REQ-032 N=4, buttons pressed then released with a 2-cycle bounce high mid-release -> buttons[0] falls once, zero extra press pulses.
REQ-033 N=4, switches_raw 000 -> 3FF held -> switches=3FF and switches_changed pulse once, 6 edges after first sample; single-bit 1-cycle glitch afterwards -> no update.
REQ-034 rst asserted for 1 cycle during RISE_CHK with buttons_raw=11 held -> all outputs 0 during reset, then both press pulses in the same cycle N+2 edges after release.
REQ-035 N=1, buttons_raw=10 held from edge k -> buttons=10 after edge k+3.
